// File: rtl/riscv_mem_pkg.sv
// Shared memory-system constants for the multi-cycle RISC-V CPU, plus the
// dump engine's FSM state type.
//   ADDR_W     : DMemory word-address width
//   DATA_W     : data word width
//   DMEM_DEPTH : DMemory depth in words
package riscv_mem_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int DMEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_e;

endpackage

// File: rtl/dmem_dump_unit_fifo.sv
// dump_skid_fifo: two-entry FIFO holding {address, data} pairs returned by
// DMemory while the stream consumer stalls.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : entry to write
//   rdata_o    : head entry
//   full_o     : two entries held
//   empty_o    : no entries held
//   count_o    : number of entries held, 0..2
module dump_skid_fifo #(
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_dump_unit.sv
// dmem_dump_unit: walks a contiguous word range of DMemory through its
// synchronous read port and streams every word, tagged with its address,
// over a valid/ready interface.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : dump request (sampled only when idle)
//   first_addr          : first word address of the range
//   word_count          : number of words, 0..2^ADDR_W
//   mem_rd_en, mem_addr : read strobe/address to DMemory
//   mem_rdata           : read data, valid the cycle after mem_rd_en
//   out_valid/out_ready : stream handshake
//   out_data, out_addr  : streamed word and its address
//   out_last            : final word of the range
//   busy                : dump in progress
//   done                : one-cycle pulse once the final word is accepted
module dmem_dump_unit #(
    parameter int ADDR_W = riscv_mem_pkg::ADDR_W,
    parameter int DATA_W = riscv_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import riscv_mem_pkg::*;

    localparam int              FW      = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    dump_state_e       state_q;
    logic [ADDR_W-1:0] iss_ptr_q;
    logic [ADDR_W:0]   iss_rem_q;
    logic [ADDR_W:0]   acc_rem_q;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rvalid_q;    // mem_rdata carries a word this cycle
    logic [ADDR_W-1:0] raddr_q;     // address of that word
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic [FW-1:0]     fifo_head;
    logic              bypass;
    logic              hs;
    logic              push;
    logic              pop;
    logic [1:0]        occ_nxt;
    logic [2:0]        commit_nxt;
    logic              can_issue;

    // Returning data flows straight to the stream when the FIFO is empty, so
    // a word is offered in the same cycle it comes back from memory. It is
    // only written into the FIFO if the consumer does not take it at once;
    // out_data/out_addr therefore stay put across a stall.
    assign bypass    = fifo_empty && rvalid_q;
    assign out_valid = !fifo_empty || rvalid_q;
    assign hs        = out_valid && out_ready;
    assign pop       = hs && !fifo_empty;
    assign push      = rvalid_q && !(bypass && out_ready) && !fifo_full;

    assign out_data = !fifo_empty ? fifo_head[DATA_W-1:0]
                                  : (rvalid_q ? mem_rdata : '0);
    assign out_addr = !fifo_empty ? fifo_head[FW-1:DATA_W]
                                  : (rvalid_q ? raddr_q : '0);
    assign out_last = out_valid && (acc_rem_q == CNT_ONE);

    // Words buffered next cycle plus the read issued this cycle (its data
    // arrives next cycle). A new read is only allowed if every committed
    // word still fits in the two FIFO slots.
    always_comb begin
        occ_nxt = fifo_cnt;
        if (push && !pop) begin
            occ_nxt = fifo_cnt + 2'd1;
        end else if (pop && !push) begin
            occ_nxt = fifo_cnt - 2'd1;
        end
    end

    assign commit_nxt = {1'b0, occ_nxt} + {2'b00, mem_rd_en_q};
    assign can_issue  = (iss_rem_q != '0) && (commit_nxt < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            iss_ptr_q   <= '0;
            iss_rem_q   <= '0;
            acc_rem_q   <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rvalid_q    <= 1'b0;
            raddr_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rvalid_q    <= mem_rd_en_q;
            raddr_q     <= mem_addr_q;
            if (hs) begin
                acc_rem_q <= acc_rem_q - 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // First read goes out straight away.
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= first_addr;
                            iss_ptr_q   <= first_addr + 1'b1;
                            iss_rem_q   <= word_count - 1'b1;
                            acc_rem_q   <= word_count;
                            state_q     <= (word_count == CNT_ONE) ? ST_DRAIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (can_issue) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= iss_ptr_q;
                        iss_ptr_q   <= iss_ptr_q + 1'b1;   // wraps at top of memory
                        iss_rem_q   <= iss_rem_q - 1'b1;
                        if (iss_rem_q == CNT_ONE) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (hs && (acc_rem_q == CNT_ONE)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    dump_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({raddr_q, mem_rdata}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: doc/dmem_dump_unit.md
# dmem_dump_unit

Read-side dump engine for the multi-cycle RISC-V CPU's data memory. On `start` it walks a contiguous word range of DMemory through a synchronous-read port and streams each word, tagged with its address, over a valid/ready interface. Simulation uses it for end-of-run result extraction; hardware uses it for a debug/UART readout path. It is the reader counterpart to the memory-image loading done at initialisation.

## Interface
- `ADDR_W`, 10, word-address width (1024-word DMemory)
- `DATA_W`, 32, data word width
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `first_addr`  in  ADDR_W  first word address; captured with `start`
- `word_count`  in  ADDR_W+1  words to dump, 0..1024; captured with `start`
- `mem_rd_en`  out  1  read strobe to DMemory port
- `mem_addr`  out  ADDR_W  read address
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  consumer accepts word when `out_valid && out_ready`
- `out_data`  out  DATA_W  word value
- `out_addr`  out  ADDR_W  address the word came from
- `out_last`  out  1  high with the final word of the range
- `busy`  out  1  high from the cycle after `start` until the cycle `done` is high
- `done`  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start` with `word_count`>0 → RUN; issue pointer = `first_addr`, issue remaining = `word_count`, accept remaining = `word_count`. `start` with `word_count`=0 → stay IDLE, `done` pulses next cycle, no reads, no output.
- RUN: a read issues when issue remaining>0 and (buffer occupancy + reads in flight) < 2. Issue pointer increments mod 2^ADDR_W (wraps 1023→0). When issue remaining reaches 0 → DRAIN.
- DRAIN: no reads; when accept remaining reaches 0 → IDLE, `done` pulses that cycle.
- Returned `mem_rdata` is written into a 2-entry FIFO with its address; the FIFO head drives `out_*`. `out_last` = head is the final word (accept remaining = 1).
- `start` while `busy` is ignored; captured range is unaffected.
- `out_data`/`out_addr` hold steady while `out_valid && !out_ready`.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0; FIFO emptied, in-flight read discarded.
- Reset mid-dump: returns to IDLE next edge; the pending `mem_rdata` is not captured; no `done`.
- `start` sampled at edge T: `busy` and first `mem_rd_en` high in cycle T+1; data captured at edge T+2; `out_valid` high in cycle T+2.
- `out_ready` held high: one word per cycle; N words finish their last handshake in cycle T+N+1, `done` high in cycle T+N+2, `busy` falls with it.
- Backpressure: at most 2 words buffered + 0 in flight, or 1 buffered + 1 in flight; never overflows. Reads resume the cycle after a pop frees room.
- Simultaneous FIFO push and pop in one cycle are both honoured; occupancy unchanged.

## Structure
- `riscv_mem_pkg`: `ADDR_W`, `DATA_W`, `DMEM_DEPTH`=1024, shared with CPU memories and benches.
- Sub-module `dump_skid_fifo`: 2-entry FIFO, width DATA_W+ADDR_W, push/pop/full/empty/count; all else in the top FSM.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles; `start` with `word_count`=0 → no `mem_rd_en`, `done` one cycle later.
- DMemory[i]=i*3; `first_addr`=0, `word_count`=1024, `out_ready`=1 → words 0,3,…,3069 in order, `out_last` only at addr 1023, `done` at T+1026.
- `first_addr`=1022, `word_count`=4 → addresses 1022,1023,0,1 (wrap), 4 words, `out_last` at addr 1.
- `word_count`=8, `out_ready` toggled pseudo-randomly → exactly 8 handshakes, no drop/duplicate, `out_*` stable while stalled, `mem_rd_en` never high with 2 entries committed.
- `start` pulsed again mid-dump with `first_addr`=500 → ignored; original range completes unchanged.
- `rst_n` low for 1 cycle after 3 of 10 words accepted → outputs to reset values next cycle, no `done`; fresh `start` then dumps cleanly.
